spram_be_ctrl: RTL

//  Parametrised single-port RAM, next generation of the team's 16x8 single-port memory.

---
 rtl/spram_pkg.sv | 37 +++
 rtl/spram_clear_ctrl.sv | 72 +++++++
 rtl/spram_be_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/spram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spram_pkg
//  Description : Shared types and helpers for the byte-enable single-port RAM.
//                - spram_state_t : clear-FSM state encoding
//                - be_merge      : byte-masked merge of an old and a new word
//  Revision    : 1.0  initial release
// ============================================================================
package spram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } spram_state_t;

    // be_merge works on a fixed maximum width so one function serves every
    // DATA_W; callers zero-extend their operands and keep the low DATA_W bits.
    localparam int SPRAM_MAX_DW = 256;
    localparam int SPRAM_MAX_BE = SPRAM_MAX_DW / 8;

    function automatic logic [SPRAM_MAX_DW-1:0] be_merge(
        input logic [SPRAM_MAX_DW-1:0] old_word,
        input logic [SPRAM_MAX_DW-1:0] new_word,
        input logic [SPRAM_MAX_BE-1:0] be
    );
        logic [SPRAM_MAX_DW-1:0] merged;
        merged = old_word;
        for (int k = 0; k < SPRAM_MAX_BE; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spram_clear_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spram_clear_ctrl
//  Description : Clear sequencer for the single-port RAM. After reset, or on a
//                clr pulse while idle, it walks clr_ptr over every word for
//                exactly DEPTH cycles, then raises ready.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                clr           - request a re-clear (honoured only when idle)
//                clear_we      - array write strobe for the clear walk
//                clr_ptr       - word address being cleared
//                ready         - registered, high while idle
//  Revision    : 1.0  initial release
// ============================================================================
module spram_clear_ctrl
    import spram_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clr_ptr,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    spram_state_t      r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // clr is ignored here: the walk always runs to completion
                    if (r_clr_ptr == c_LAST) begin
                        r_state   <= ST_IDLE;
                        r_clr_ptr <= '0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= '0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_clr_ptr <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    assign clear_we = (r_state == ST_CLEAR);
    assign clr_ptr  = r_clr_ptr;
    assign ready    = r_ready;

endmodule
`default_nettype wire

// File: rtl/spram_be_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spram_be_ctrl
//  Description : Parametrised single-port RAM with per-byte write enables,
//                req/ready handshake, optional output register and a clear
//                sequencer that zeroes the array after reset or on clr.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                req, wr       - access request (accepted when ready), 1=write
//                be, addr, din - byte enables, word address, write data
//                clr           - re-zero the array (taken when idle)
//                ready         - accepting requests
//                dout          - read / write-through data (held when idle)
//                dout_valid    - one-cycle qualifier for dout
//                err           - one-cycle pulse for an out-of-range access
//  Revision    : 1.0  initial release
// ============================================================================
module spram_be_ctrl
    import spram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int BE_W    = DATA_W / 8,
    parameter int OUT_REG = 0,
    parameter int WR_THRU = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic              clr,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              err
);

    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]       r_mem [DEPTH];

    logic                    w_clear_we;
    logic [ADDR_W-1:0]       w_clr_ptr;
    logic                    w_accept;
    logic                    w_in_range;
    logic [DATA_W-1:0]       w_rd_word;
    logic [SPRAM_MAX_DW-1:0] w_merge_full;
    logic [DATA_W-1:0]       w_merged;
    logic                    w_rsp_valid;
    logic                    w_rsp_err;
    logic [DATA_W-1:0]       w_rsp_data;

    logic [DATA_W-1:0]       r_dout;
    logic                    r_dout_valid;
    logic                    r_err;

    spram_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .clear_we (w_clear_we),
        .clr_ptr  (w_clr_ptr),
        .ready    (ready)
    );

    // A request coinciding with reset is never taken.
    assign w_accept   = req & ready & ~rst;
    assign w_in_range = ({1'b0, addr} < c_DEPTH);
    assign w_rd_word  = w_in_range ? r_mem[addr] : '0;

    assign w_merge_full = be_merge(SPRAM_MAX_DW'(w_rd_word),
                                   SPRAM_MAX_DW'(din),
                                   SPRAM_MAX_BE'(be));
    assign w_merged     = w_merge_full[DATA_W-1:0];

    if (DATA_W < SPRAM_MAX_DW) begin : g_merge_pad
        logic w_merge_unused;
        assign w_merge_unused = ^w_merge_full[SPRAM_MAX_DW-1:DATA_W];
    end

    // The clear walk and user accesses never overlap (ready is low during
    // CLEAR), so the port mux is a simple priority select.
    always_ff @(posedge clk) begin
        if (w_clear_we) begin
            r_mem[w_clr_ptr] <= '0;
        end else if (w_accept && wr && w_in_range) begin
            r_mem[addr] <= w_merged;
        end
    end

    // Response formed in the accept cycle: reads always respond, writes only
    // in write-through mode; out-of-range accesses answer with zero.
    assign w_rsp_valid = w_accept & (~wr | (WR_THRU != 0));
    assign w_rsp_err   = w_accept & ~w_in_range;
    assign w_rsp_data  = wr ? (w_in_range ? w_merged : '0) : w_rd_word;

    if (OUT_REG != 0) begin : g_out_reg
        logic              r_p1_valid;
        logic              r_p1_err;
        logic [DATA_W-1:0] r_p1_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_p1_valid   <= 1'b0;
                r_p1_err     <= 1'b0;
                r_p1_data    <= '0;
                r_dout_valid <= 1'b0;
                r_err        <= 1'b0;
                r_dout       <= '0;
            end else begin
                r_p1_valid   <= w_rsp_valid;
                r_p1_err     <= w_rsp_err;
                if (w_rsp_valid) begin
                    r_p1_data <= w_rsp_data;
                end
                r_dout_valid <= r_p1_valid;
                r_err        <= r_p1_err;
                if (r_p1_valid) begin
                    r_dout <= r_p1_data;
                end
            end
        end
    end else begin : g_no_out_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout_valid <= 1'b0;
                r_err        <= 1'b0;
                r_dout       <= '0;
            end else begin
                r_dout_valid <= w_rsp_valid;
                r_err        <= w_rsp_err;
                if (w_rsp_valid) begin
                    r_dout <= w_rsp_data;
                end
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign err        = r_err;

endmodule
`default_nettype wire
